// File: rtl/tv80_regfile_banked.sv
// tv80_regfile_banked
// Banked TV80 register-pair file. It has three asynchronous read ports (A/B/C) and
// one byte-enabled write port on address A. The EXX-style bank swap works on the
// pairs selected by BANKED_MASK. A sequencer zeroes the whole file after reset.
// A two-stage pair increment/decrement unit writes its result back on the next
// enabled cycle.
// Optional feature: define REGFILE_BYPASS_EN to forward port-A write data to the
// read ports and to bc/de/hl in the same cycle.
module tv80_regfile_banked #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int NUM_BANKS = 2,
    parameter logic [(2**ADDR_W)-1:0] BANKED_MASK = 8'b0000_0111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cen,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [ADDR_W-1:0]   addr_c,
    input  logic                we_h,
    input  logic                we_l,
    input  logic [DATA_W-1:0]   di_h,
    input  logic [DATA_W-1:0]   di_l,
    input  logic                exx,
    input  logic                incdec_req,
    input  logic                incdec_dir,
    input  logic [ADDR_W-1:0]   incdec_addr,
    output logic [DATA_W-1:0]   do_a_h,
    output logic [DATA_W-1:0]   do_a_l,
    output logic [DATA_W-1:0]   do_b_h,
    output logic [DATA_W-1:0]   do_b_l,
    output logic [DATA_W-1:0]   do_c_h,
    output logic [DATA_W-1:0]   do_c_l,
    output logic [2*DATA_W-1:0] bc,
    output logic [2*DATA_W-1:0] de,
    output logic [2*DATA_W-1:0] hl,
    output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_sel,
    output logic                clear_busy,
    output logic                incdec_busy,
    output logic                incdec_done
);

    localparam int NPAIRS = 2**ADDR_W;
    localparam int DEPTH  = NUM_BANKS * NPAIRS;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PHYS_W = BANK_W + ADDR_W;
    localparam int PAIR_W = 2 * DATA_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [PHYS_W-1:0] LAST_IDX  = PHYS_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    logic [DATA_W-1:0] mem_h [DEPTH];
    logic [DATA_W-1:0] mem_l [DEPTH];

    logic [0:0]        state;
    logic [PHYS_W-1:0] cnt;
    logic [PHYS_W-1:0] id_idx;
    logic              id_dir;
    logic [PAIR_W-1:0] id_val;
    logic [PAIR_W-1:0] id_result;

    logic              run;
    logic              a_write;
    logic              commit;
    logic              conflict;
    logic [PHYS_W-1:0] pa, pb, pc, pi;

    // Map a pair address to its physical entry; unbanked pairs always live in bank 0.
    function automatic logic [PHYS_W-1:0] phys(input logic [ADDR_W-1:0] pair,
                                               input logic [BANK_W-1:0] bank);
        return {BANKED_MASK[pair] ? bank : {BANK_W{1'b0}}, pair};
    endfunction

    // Read one physical pair. It returns zero while clearing and forwards same-cycle
    // write data when the bypass feature is enabled.
    function automatic logic [PAIR_W-1:0] rd_pair(input logic [PHYS_W-1:0] idx);
        logic [PAIR_W-1:0] v;
        v = {mem_h[idx], mem_l[idx]};
`ifdef REGFILE_BYPASS_EN
        if (cen && idx == pa) begin
            if (we_h) v[PAIR_W-1:DATA_W] = di_h;
            if (we_l) v[DATA_W-1:0]      = di_l;
        end
`endif
        if (!run) v = '0;
        return v;
    endfunction

    assign run        = (state == ST_RUN);
    assign clear_busy = (state == ST_CLEAR);
    assign pa = phys(addr_a, bank_sel);
    assign pb = phys(addr_b, bank_sel);
    assign pc = phys(addr_c, bank_sel);
    assign pi = phys(incdec_addr, bank_sel);

    // A port-A write to the pending pair cancels the whole incdec result, but
    // incdec_done still pulses.
    assign a_write     = run & cen & ~reset & (we_h | we_l);
    assign commit      = run & cen & ~reset & incdec_busy;
    assign conflict    = a_write & (pa == id_idx);
    assign incdec_done = commit;
    assign id_result   = id_dir ? id_val - PAIR_W'(1) : id_val + PAIR_W'(1);

    // Asynchronous read ports and the fixed BC/DE/HL views of the current bank.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
        {do_a_h, do_a_l} = '0;
        {do_b_h, do_b_l} = '0;
        {do_c_h, do_c_l} = '0;
        bc = '0;
        de = '0;
        hl = '0;
        {do_a_h, do_a_l} = rd_pair(pa);
        {do_b_h, do_b_l} = rd_pair(pb);
        {do_c_h, do_c_l} = rd_pair(pc);
        bc = rd_pair(phys(ADDR_W'(0), bank_sel));
        de = rd_pair(phys(ADDR_W'(1), bank_sel));
        hl = rd_pair(phys(ADDR_W'(2), bank_sel));
    end

    // Storage: the clear sequencer writes zero, then port A and the incdec writeback take over.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch. The clear sequencer zeroes it one
        // entry per cycle, so it maps onto plain RAM-style storage.
        if (state == ST_CLEAR) begin
            mem_h[cnt] <= '0;
            mem_l[cnt] <= '0;
        end else begin
            if (commit && !conflict) begin
                mem_h[id_idx] <= id_result[PAIR_W-1:DATA_W];
                mem_l[id_idx] <= id_result[DATA_W-1:0];
            end
            if (a_write && we_h) mem_h[pa] <= di_h;
            if (a_write && we_l) mem_l[pa] <= di_l;
        end
    end

    // Control: clear sequencer, bank selection and the incdec accept/commit handshake.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments, so every flop sees pre-edge values.
        if (reset) begin
            state       <= ST_CLEAR;
            cnt         <= '0;
            bank_sel    <= '0;
            incdec_busy <= 1'b0;
            id_idx      <= '0;
            id_dir      <= 1'b0;
            id_val      <= '0;
        end else if (state == ST_CLEAR) begin
            if (cnt == LAST_IDX) begin
                state <= ST_RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + PHYS_W'(1);
            end
        end else if (cen) begin
            if (exx) bank_sel <= (bank_sel == LAST_BANK) ? '0 : bank_sel + BANK_W'(1);
            if (incdec_busy) begin
                incdec_busy <= 1'b0;
            end else if (incdec_req) begin
                incdec_busy <= 1'b1;
                id_idx      <= pi;
                id_dir      <= incdec_dir;
                id_val      <= {mem_h[pi], mem_l[pi]};
            end
        end
    end

endmodule
